// File: rtl/pbvi_iter_ctrl_if.sv
// Host/pipeline-facing bundle of the PBVI iteration sequencer.
// master: host configuration and backup-pipeline side; slave: the sequencer.
interface pbvi_iter_ctrl_if #(
    parameter int N_POINT = 16,
    parameter int DATA_W  = 16,
    parameter int IT_W    = 8
);
    // Host control and run configuration
    logic                                start;
    logic                                abort;
    logic [IT_W-1:0]                     max_iter;
    logic [DATA_W-1:0]                   epsilon;
    logic [N_POINT-1:0][1:0][DATA_W-1:0] alpha_init;

    // Backup pipeline handshake and data
    logic                                pipe_en;
    logic                                pipe_done;
    logic [N_POINT-1:0][1:0][DATA_W-1:0] alpha_cur;
    logic [N_POINT-1:0][1:0][DATA_W-1:0] alpha_res;
    logic [N_POINT-1:0][1:0]             action_res;

    // Results and status
    logic [N_POINT-1:0][1:0]             policy;
    logic                                busy;
    logic                                done;
    logic                                converged;
    logic                                timeout;
    logic [IT_W-1:0]                     iter_count;

    modport master (
        output start,
        output abort,
        output max_iter,
        output epsilon,
        output alpha_init,
        output pipe_done,
        output alpha_res,
        output action_res,
        input  pipe_en,
        input  alpha_cur,
        input  policy,
        input  busy,
        input  done,
        input  converged,
        input  timeout,
        input  iter_count
    );

    modport slave (
        input  start,
        input  abort,
        input  max_iter,
        input  epsilon,
        input  alpha_init,
        input  pipe_done,
        input  alpha_res,
        input  action_res,
        output pipe_en,
        output alpha_cur,
        output policy,
        output busy,
        output done,
        output converged,
        output timeout,
        output iter_count
    );
endinterface

// File: rtl/pbvi_iter_ctrl.sv
// PBVI iteration sequencer.
// Owns the current alpha-vector set, launches one Bellman backup pass per
// iteration, compares the returned set element by element against the
// current one, commits it, and stops on convergence, iteration limit or
// watchdog expiry. Every output is taken straight from a flop.
module pbvi_iter_ctrl #(
    parameter int N_POINT   = 16,
    parameter int DATA_W    = 16,
    parameter int IT_W      = 8,
    parameter int WD_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    pbvi_iter_ctrl_if.slave bus
);

    typedef logic [N_POINT-1:0][1:0][DATA_W-1:0] alpha_t;
    typedef logic [N_POINT-1:0][1:0]             pol_t;

    localparam int IDX_W = (2 * N_POINT > 2) ? $clog2(2 * N_POINT) : 1;
    localparam int PT_W  = (IDX_W > 1) ? IDX_W - 1 : 1;
    localparam int WD_W  = $clog2(WD_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * N_POINT - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_CYCLES - 1);
    localparam logic [IT_W-1:0]  IT_MAX   = {IT_W{1'b1}};
    localparam logic [IT_W-1:0]  IT_ONE   = IT_W'(1);
    localparam logic [IT_W-1:0]  IT_ZERO  = {IT_W{1'b0}};

    // Controller states (plain constants so the encoding stays fixed)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_KICK = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Larger minus smaller: the result always fits in DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_diff(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Registered state
    logic [2:0]        state_r;
    alpha_t            alpha_cur_r;
    alpha_t            cand_r;
    pol_t              policy_r;
    pol_t              cand_pol_r;
    logic [IT_W-1:0]   iter_r;
    logic [IT_W-1:0]   max_iter_r;
    logic [DATA_W-1:0] eps_r;
    logic [WD_W-1:0]   wd_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] run_max_r;
    logic              conv_r;
    logic              tout_r;
    logic              pipe_en_r;
    logic              busy_r;
    logic              done_r;

    // Next-state values
    logic [2:0]        state_s;
    alpha_t            alpha_cur_s;
    alpha_t            cand_s;
    pol_t              policy_s;
    pol_t              cand_pol_s;
    logic [IT_W-1:0]   iter_s;
    logic [IT_W-1:0]   max_iter_s;
    logic [DATA_W-1:0] eps_s;
    logic [WD_W-1:0]   wd_s;
    logic [IDX_W-1:0]  idx_s;
    logic [DATA_W-1:0] run_max_s;
    logic              conv_s;
    logic              tout_s;

    // Compare datapath for the element selected by idx
    logic [PT_W-1:0]   pt_s;
    logic              comp_s;
    logic [DATA_W-1:0] cand_elem_s;
    logic [DATA_W-1:0] cur_elem_s;
    logic [DATA_W-1:0] diff_s;
    logic [DATA_W-1:0] max_s;
    logic [IT_W-1:0]   iter_inc_s;

    assign pt_s        = PT_W'(idx_r >> 1);
    assign comp_s      = idx_r[0];
    assign cand_elem_s = cand_r[pt_s][comp_s];
    assign cur_elem_s  = alpha_cur_r[pt_s][comp_s];
    assign diff_s      = abs_diff(cand_elem_s, cur_elem_s);
    assign max_s       = (diff_s > run_max_r) ? diff_s : run_max_r;
    assign iter_inc_s  = (iter_r == IT_MAX) ? iter_r : iter_r + IT_ONE;

    // Next-state and datapath update; abort overrides everything else
    always_comb begin
        state_s     = state_r;
        alpha_cur_s = alpha_cur_r;
        cand_s      = cand_r;
        policy_s    = policy_r;
        cand_pol_s  = cand_pol_r;
        iter_s      = iter_r;
        max_iter_s  = max_iter_r;
        eps_s       = eps_r;
        wd_s        = wd_r;
        idx_s       = idx_r;
        run_max_s   = run_max_r;
        conv_s      = conv_r;
        tout_s      = tout_r;

        if (bus.abort) begin
            // Committed set, policy and count survive an abort
            state_s = ST_IDLE;
            conv_s  = 1'b0;
            tout_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        alpha_cur_s = bus.alpha_init;
                        max_iter_s  = bus.max_iter;
                        eps_s       = bus.epsilon;
                        iter_s      = IT_ZERO;
                        conv_s      = 1'b0;
                        tout_s      = 1'b0;
                        run_max_s   = {DATA_W{1'b0}};
                        state_s     = ST_KICK;
                    end else begin
                        state_s = state_r;
                    end
                end

                ST_KICK: begin
                    wd_s    = {WD_W{1'b0}};
                    state_s = ST_WAIT;
                end

                ST_WAIT: begin
                    // A completing pass beats a watchdog expiring in the same cycle
                    if (bus.pipe_done) begin
                        cand_s     = bus.alpha_res;
                        cand_pol_s = bus.action_res;
                        idx_s      = {IDX_W{1'b0}};
                        run_max_s  = {DATA_W{1'b0}};
                        state_s    = ST_CMP;
                    end else if (wd_r == WD_LAST) begin
                        tout_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        wd_s = wd_r + WD_W'(1);
                    end
                end

                ST_CMP: begin
                    run_max_s = max_s;
                    if (idx_r == IDX_LAST) begin
                        alpha_cur_s = cand_r;
                        policy_s    = cand_pol_r;
                        iter_s      = iter_inc_s;
                        if (max_s <= eps_r) begin
                            conv_s  = 1'b1;
                            state_s = ST_DONE;
                        end else if ((max_iter_r != IT_ZERO) && (iter_inc_s == max_iter_r)) begin
                            conv_s  = 1'b0;
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_KICK;
                        end
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end

                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers; outputs derive from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            alpha_cur_r <= '0;
            cand_r      <= '0;
            policy_r    <= '0;
            cand_pol_r  <= '0;
            iter_r      <= IT_ZERO;
            max_iter_r  <= IT_ZERO;
            eps_r       <= {DATA_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            run_max_r   <= {DATA_W{1'b0}};
            conv_r      <= 1'b0;
            tout_r      <= 1'b0;
            pipe_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            alpha_cur_r <= alpha_cur_s;
            cand_r      <= cand_s;
            policy_r    <= policy_s;
            cand_pol_r  <= cand_pol_s;
            iter_r      <= iter_s;
            max_iter_r  <= max_iter_s;
            eps_r       <= eps_s;
            wd_r        <= wd_s;
            idx_r       <= idx_s;
            run_max_r   <= run_max_s;
            conv_r      <= conv_s;
            tout_r      <= tout_s;
            pipe_en_r   <= (state_s == ST_KICK);
            busy_r      <= (state_s == ST_KICK) || (state_s == ST_WAIT) || (state_s == ST_CMP);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign bus.pipe_en    = pipe_en_r;
    assign bus.alpha_cur  = alpha_cur_r;
    assign bus.policy     = policy_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.converged  = conv_r;
    assign bus.timeout    = tout_r;
    assign bus.iter_count = iter_r;

endmodule
